alu_operand_stage: RTL and testbench

//  Upstream feeder for the 16-bit ALU (ports Ain, Bin, ALUop in; out, Z back).

---
 rtl/alu_operand_stage.sv | 139 +++++++++++++
 tb/tb_alu_operand_stage.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_stage.sv
// Operand feeder for a combinational 16-bit ALU: register file, A/B operand registers,
// B-path shifter and a five-state sequencer that runs one instruction per start.
module alu_operand_stage #(
  parameter  int DW   = 16,
  parameter  int NREG = 8,
  localparam int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [1:0]    op,
  input  logic [AW-1:0] rn,
  input  logic [AW-1:0] rm,
  input  logic [AW-1:0] rd,
  input  logic [1:0]    shift,
  input  logic          use_imm,
  input  logic [DW-1:0] imm,
  input  logic          ext_we,
  input  logic [AW-1:0] ext_addr,
  input  logic [DW-1:0] ext_data,
  output logic [DW-1:0] Ain,
  output logic [DW-1:0] Bin,
  output logic [1:0]    ALUop,
  input  logic [DW-1:0] alu_out,
  input  logic          alu_Z,
  output logic [DW-1:0] C,
  output logic          Z_flag,
  output logic          busy,
  output logic          done
);

  // state  | meaning
  // -------+-----------------------------------------------
  // IDLE   | waiting for start; external register loads
  // RD_A   | A <= R[rn]
  // RD_B   | B <= R[rm]
  // EXEC   | ALU inputs stable; capture out/Z at edge
  // WB     | R[rd] <= C; done pulse
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD_A = 3'd1;
  localparam logic [2:0] S_RD_B = 3'd2;
  localparam logic [2:0] S_EXEC = 3'd3;
  localparam logic [2:0] S_WB   = 3'd4;

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL  = 2'b01;
  localparam logic [1:0] SH_LSR  = 2'b10;
  localparam logic [1:0] SH_ASR  = 2'b11;

  logic [2:0]    state;
  logic [DW-1:0] regs [NREG];
  logic [DW-1:0] a_q;
  logic [DW-1:0] b_q;
  logic [DW-1:0] c_q;
  logic          z_q;

  logic [1:0]    op_q;
  logic [AW-1:0] rn_q;
  logic [AW-1:0] rm_q;
  logic [AW-1:0] rd_q;
  logic [1:0]    shift_q;
  logic          use_imm_q;
  logic [DW-1:0] imm_q;

  logic [DW-1:0] b_shifted;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      z_q       <= 1'b0;
      op_q      <= '0;
      rn_q      <= '0;
      rm_q      <= '0;
      rd_q      <= '0;
      shift_q   <= '0;
      use_imm_q <= 1'b0;
      imm_q     <= '0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // A same-cycle external load is visible to the RD_A/RD_B reads that follow.
          if (ext_we) regs[ext_addr] <= ext_data;
          if (start) begin
            op_q      <= op;
            rn_q      <= rn;
            rm_q      <= rm;
            rd_q      <= rd;
            shift_q   <= shift;
            use_imm_q <= use_imm;
            imm_q     <= imm;
            state     <= S_RD_A;
          end
        end
        S_RD_A: begin
          a_q   <= regs[rn_q];
          state <= S_RD_B;
        end
        S_RD_B: begin
          b_q   <= regs[rm_q];
          state <= S_EXEC;
        end
        S_EXEC: begin
          c_q   <= alu_out;
          z_q   <= alu_Z;
          state <= S_WB;
        end
        S_WB: begin
          regs[rd_q] <= c_q;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    b_shifted = b_q;
    case (shift_q)
      SH_NONE: b_shifted = b_q;
      SH_LSL:  b_shifted = {b_q[DW-2:0], 1'b0};
      SH_LSR:  b_shifted = {1'b0, b_q[DW-1:1]};
      SH_ASR:  b_shifted = {b_q[DW-1], b_q[DW-1:1]};
      default: b_shifted = b_q;
    endcase
  end

  assign Ain    = a_q;
  assign Bin    = use_imm_q ? imm_q : b_shifted;
  assign ALUop  = op_q;
  assign C      = c_q;
  assign Z_flag = z_q;
  assign busy   = (state != S_IDLE);
  assign done   = (state == S_WB);

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage with a behavioural combinational ALU attached
// to the Ain/Bin/ALUop/alu_out/alu_Z loop.
module tb_alu_operand_stage;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_NOT = 2'b11;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [2:0]  rn, rm, rd;
  logic [1:0]  shift;
  logic        use_imm;
  logic [15:0] imm;
  logic        ext_we;
  logic [2:0]  ext_addr;
  logic [15:0] ext_data;
  logic [15:0] Ain, Bin;
  logic [1:0]  ALUop;
  logic [15:0] alu_out;
  logic        alu_Z;
  logic [15:0] C;
  logic        Z_flag;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  alu_operand_stage dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rn(rn), .rm(rm), .rd(rd),
    .shift(shift), .use_imm(use_imm), .imm(imm), .ext_we(ext_we), .ext_addr(ext_addr),
    .ext_data(ext_data), .Ain(Ain), .Bin(Bin), .ALUop(ALUop), .alu_out(alu_out),
    .alu_Z(alu_Z), .C(C), .Z_flag(Z_flag), .busy(busy), .done(done)
  );

  always_comb begin
    alu_out = 16'h0000;
    case (ALUop)
      OP_ADD:  alu_out = Ain + Bin;
      OP_SUB:  alu_out = Ain - Bin;
      OP_AND:  alu_out = Ain & Bin;
      OP_NOT:  alu_out = ~Bin;
      default: alu_out = 16'h0000;
    endcase
  end
  assign alu_Z = (alu_out == 16'h0000);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic write_reg(input logic [2:0] idx, input logic [15:0] val);
    ext_addr = idx;
    ext_data = val;
    ext_we   = 1'b1;
    @(posedge clk); #1;
    ext_we   = 1'b0;
  endtask

  // inj: 0 none, 1 start in RD_B, 2 ext_we in EXEC, 3 reset in EXEC, 4 ext_we with start
  task automatic run(input logic [1:0] op_i, input logic [2:0] rn_i, input logic [2:0] rm_i,
                     input logic [2:0] rd_i, input logic [1:0] sh_i, input logic ui,
                     input logic [15:0] imm_i, input int inj,
                     output logic [15:0] bin_seen, output int lat, output int ndone);
    op = op_i; rn = rn_i; rm = rm_i; rd = rd_i; shift = sh_i; use_imm = ui; imm = imm_i;
    start = 1'b1;
    if (inj == 4) ext_we = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ext_we = 1'b0;
    bin_seen = 16'hxxxx;
    lat = 0;
    ndone = 0;
    for (int c = 1; c <= 12; c++) begin
      if (!busy) break;
      if (done) begin
        ndone++;
        lat = c;
      end
      if (c == 2 && inj == 1) start = 1'b1;
      if (c == 3) begin
        bin_seen = Bin;
        if (inj == 2) ext_we = 1'b1;
        if (inj == 3) reset = 1'b0;
      end
      @(posedge clk); #1;
      start = 1'b0;
      ext_we = 1'b0;
      reset = 1'b1;
    end
    check_val("run_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic read_reg(input logic [2:0] idx, output logic [15:0] val);
    logic [15:0] b;
    int l, n;
    run(OP_ADD, idx, 3'd0, 3'd7, 2'b00, 1'b1, 16'h0000, 0, b, l, n);
    val = C;
  endtask

  initial begin
    logic [15:0] bin_v;
    logic [15:0] rv;
    int lat, nd;

    reset = 1'b0; start = 1'b0; op = 2'b00; rn = '0; rm = '0; rd = '0; shift = 2'b00;
    use_imm = 1'b0; imm = '0; ext_we = 1'b0; ext_addr = '0; ext_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_done", {31'd0, done}, 32'd0);
    check_val("rst_C", {16'd0, C}, 32'h0);
    check_val("rst_Z", {31'd0, Z_flag}, 32'd0);
    check_val("rst_Ain", {16'd0, Ain}, 32'h0);
    check_val("rst_Bin", {16'd0, Bin}, 32'h0);
    check_val("rst_ALUop", {30'd0, ALUop}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    write_reg(3'd1, 16'd13);
    write_reg(3'd2, 16'd6);
    run(OP_ADD, 3'd1, 3'd2, 3'd3, 2'b00, 1'b0, 16'h0, 0, bin_v, lat, nd);
    check_val("add_lat", lat, 4);
    check_val("add_ndone", nd, 1);
    check_val("add_C", {16'd0, C}, 32'd19);
    check_val("add_Z", {31'd0, Z_flag}, 32'd0);
    read_reg(3'd3, rv);
    check_val("add_R3", {16'd0, rv}, 32'd19);

    run(OP_SUB, 3'd1, 3'd2, 3'd6, 2'b01, 1'b0, 16'h0, 0, bin_v, lat, nd);
    check_val("sub_Bin", {16'd0, bin_v}, 32'd12);
    check_val("sub_C", {16'd0, C}, 32'd1);
    check_val("sub_Z", {31'd0, Z_flag}, 32'd0);

    write_reg(3'd4, 16'hFFFF);
    run(OP_NOT, 3'd1, 3'd4, 3'd6, 2'b00, 1'b0, 16'h0, 0, bin_v, lat, nd);
    check_val("not_C", {16'd0, C}, 32'h0000);
    check_val("not_Z", {31'd0, Z_flag}, 32'd1);

    run(OP_AND, 3'd1, 3'd4, 3'd6, 2'b01, 1'b1, 16'h0006, 0, bin_v, lat, nd);
    check_val("imm_Bin", {16'd0, bin_v}, 32'h0006);
    check_val("imm_C", {16'd0, C}, 32'h0004);
    check_val("imm_Z", {31'd0, Z_flag}, 32'd0);

    write_reg(3'd5, 16'h8004);
    run(OP_NOT, 3'd1, 3'd5, 3'd6, 2'b11, 1'b0, 16'h0, 0, bin_v, lat, nd);
    check_val("asr_Bin", {16'd0, bin_v}, 32'hC002);
    check_val("asr_C", {16'd0, C}, 32'h3FFD);
    run(OP_NOT, 3'd1, 3'd5, 3'd6, 2'b10, 1'b0, 16'h0, 0, bin_v, lat, nd);
    check_val("lsr_Bin", {16'd0, bin_v}, 32'h4002);
    run(OP_NOT, 3'd1, 3'd5, 3'd6, 2'b01, 1'b0, 16'h0, 0, bin_v, lat, nd);
    check_val("lsl_Bin", {16'd0, bin_v}, 32'h0008);

    run(OP_ADD, 3'd1, 3'd2, 3'd6, 2'b00, 1'b0, 16'h0, 1, bin_v, lat, nd);
    check_val("late_start_ndone", nd, 1);
    check_val("late_start_C", {16'd0, C}, 32'd19);
    @(posedge clk); #1;
    check_val("late_start_idle", {31'd0, busy}, 32'd0);

    ext_addr = 3'd1;
    ext_data = 16'h1234;
    run(OP_ADD, 3'd1, 3'd2, 3'd6, 2'b00, 1'b0, 16'h0, 2, bin_v, lat, nd);
    read_reg(3'd1, rv);
    check_val("ext_we_exec_R1", {16'd0, rv}, 32'd13);

    ext_addr = 3'd2;
    ext_data = 16'd100;
    run(OP_ADD, 3'd1, 3'd2, 3'd6, 2'b00, 1'b0, 16'h0, 4, bin_v, lat, nd);
    check_val("start_ext_C", {16'd0, C}, 32'd113);

    run(OP_ADD, 3'd1, 3'd1, 3'd1, 2'b00, 1'b0, 16'h0, 0, bin_v, lat, nd);
    check_val("rd_eq_rn_C", {16'd0, C}, 32'd26);
    read_reg(3'd1, rv);
    check_val("rd_eq_rn_R1", {16'd0, rv}, 32'd26);

    run(OP_ADD, 3'd1, 3'd2, 3'd3, 2'b00, 1'b0, 16'h0, 3, bin_v, lat, nd);
    check_val("rst_exec_ndone", nd, 0);
    check_val("rst_exec_busy", {31'd0, busy}, 32'd0);
    check_val("rst_exec_C", {16'd0, C}, 32'h0);
    read_reg(3'd3, rv);
    check_val("rst_exec_R3", {16'd0, rv}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
